irrigation_timer: RTL and testbench
===================================

// Module: irrigation_timer
// PURPOSE
//  - Phase countdown timer for the irrigation controller; sits between circuit_state and display.
//  - On each phase load, presets a 2-digit BCD count from the current state and irrigation type.
//  - Counts down once per second using an internal prescaler on clk_fg.
//  - Drives the tens/units digits shown by display and the clean_done/expired flags consumed by
//    lines_control and circuit_state.
// PARAMETERS
//  CLK_HZ      224  clk_fg frequency in Hz; the prescaler wraps at CLK_HZ-1 to make a 1 Hz tick
//  T_CLEAN     15   clean phase duration in seconds (0..39)
//  T_SPRINKLE  30   irrigation duration in seconds when type = sprinkler (0..39)
//  T_DRIP      39   irrigation duration in seconds when type = drip (0..39)
//  T_FILL      20   tank-fill phase duration in seconds (0..39)
// PORTS
//  clk_fg       in   1  system clock, 224 Hz, rising edge
//  init_pulse   in   1  reset, asynchronous, active-high
//  states       in   2  phase: 00 IDLE, 01 CLEAN, 10 IRRIGATE, 11 FILL
//  irr_type     in   2  00 none, 01 sprinkler, 10 drip, 11 reserved (same as none)
//  load         in   1  1-cycle pulse: preset the count for the current states/irr_type
//  ds           out  2  BCD tens digit (0..3)
//  us           out  4  BCD units digit (0..9)
//  expired      out  1  level: count is 00 and the phase is not IDLE
//  clean_done   out  1  1-cycle pulse when the CLEAN phase count reaches 00
//  tick_1hz     out  1  1-cycle pulse, one per second; drives the display blink
// BEHAVIOUR
//  - Reset: ds=0, us=0, expired=0, clean_done=0, tick_1hz=0, prescaler=0, FSM=IDLE.
//  - Prescaler: counts 0..CLK_HZ-1 and wraps; tick_1hz=1 on the wrap cycle.
//    A load clears the prescaler, so the first decrement comes CLK_HZ cycles after the load.
//  - FSM states:
//    - IDLE: count held. A load with states!=00 moves to RUN.
//    - RUN: on each tick, decrement the BCD count. When us=0, set us=9 and ds=ds-1.
//      When the count reaches 00, move to DONE.
//    - DONE: count held at 00; expired=1. A load re-enters RUN.
//    - Any load with states=00 goes to IDLE with count=00.
//  - Preset table (registered on the load edge; ds/us show the new value 1 cycle after load):
//    - CLEAN: T_CLEAN
//    - IRRIGATE: T_SPRINKLE or T_DRIP; with irr_type 00/11, the preset is 00 (DONE at once)
//    - FILL: T_FILL
//    - IDLE: 00
//  - Preset of 00 in a non-IDLE phase: go straight to DONE; expired=1 on the next cycle.
//    If the phase is CLEAN, also pulse clean_done for 1 cycle.
//  - clean_done: 1-cycle pulse on the cycle the FSM enters DONE while states=01. Never repeats
//    while the FSM stays in DONE.
//  - expired: registered; equals (FSM==DONE) && states!=00.
//  - load and tick in the same cycle: load wins, no decrement.
//  - states changes without a load: the count keeps running; presets happen only on load.
//  - The count never goes below 00 and never wraps.
//  - BCD is always legal: us<=9, ds<=3. Presets convert to BCD at elaboration time.
//  - init_pulse asserted mid-count: clears everything at once, asynchronously, to reset values.
// CONFIGURATION
//  TIMER_PAUSE_EN
//  - Defined: adds input `hold` (1 bit) after irr_type. While hold=1 in RUN, the prescaler and
//    count freeze and tick_1hz stays 0. Releasing hold resumes from the frozen prescaler value.
//    load still works during hold.
//  - Undefined: no hold port; the countdown is never paused.
// TESTING
//  1. Reset mid-run (ds:us=1:2), init_pulse high -> ds=0, us=0, expired=0 the same cycle,
//     without waiting for a clock edge.
//  2. load with states=01 -> ds:us=1:5 next cycle. After 224 cycles: 1:4. After 15*224 cycles:
//     0:0, expired=1, one clean_done pulse.
//  3. Borrow check: states=10, irr_type=10, load -> 3:9. Decrement to 3:0, then the next tick
//     gives 2:9, not 2:F.
//  4. states=10, irr_type=00, load -> 0:0, expired=1 next cycle; clean_done stays 0.
//  5. Assert load in the same cycle as a tick while in RUN at 0:7 with states=11 -> preset 2:0
//     wins; the next decrement comes 224 cycles later.
//  6. With TIMER_PAUSE_EN: hold=1 for 500 cycles at 1:0 -> count stays 1:0 and no tick_1hz.
//     After release, 0:9 appears after the remaining prescaler cycles.

Source files
------------

// File: rtl/irrigation_timer.sv
// Phase countdown timer: BCD seconds preset on load, decremented by a 1 Hz prescaler tick.
// Optional macro TIMER_PAUSE_EN adds a `hold` input that freezes the countdown while running.
module irrigation_timer #(
   parameter int CLK_HZ     = 224,
   parameter int T_CLEAN    = 15,
   parameter int T_SPRINKLE = 30,
   parameter int T_DRIP     = 39,
   parameter int T_FILL     = 20
) (
   input  logic       clk_fg,
   input  logic       init_pulse,
   input  logic [1:0] states,
   input  logic [1:0] irr_type,
`ifdef TIMER_PAUSE_EN
   input  logic       hold,
`endif
   input  logic       load,
   output logic [1:0] ds,
   output logic [3:0] us,
   output logic       expired,
   output logic       clean_done,
   output logic       tick_1hz
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);

   localparam logic [5:0] B_CLEAN = {2'(T_CLEAN / 10), 4'(T_CLEAN % 10)};
   localparam logic [5:0] B_SPR   = {2'(T_SPRINKLE / 10), 4'(T_SPRINKLE % 10)};
   localparam logic [5:0] B_DRIP  = {2'(T_DRIP / 10), 4'(T_DRIP % 10)};
   localparam logic [5:0] B_FILL  = {2'(T_FILL / 10), 4'(T_FILL % 10)};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_presc;
   logic [1:0]      r_ds;
   logic [3:0]      r_us;
   logic [1:0]      w_ds_nxt;
   logic [3:0]      w_us_nxt;
   logic [5:0]      w_preset;
   logic            w_hold;
   logic            w_freeze;
   logic            w_tick;
   logic            w_enter_done;
   logic            r_expired;
   logic            r_clean_done;

`ifdef TIMER_PAUSE_EN
   assign w_hold = hold;
`else
   assign w_hold = 1'b0;
`endif

   assign w_freeze = w_hold && (r_state == S_RUN);
   assign w_tick   = (r_presc == P_MAX) && !w_freeze;

   assign ds         = r_ds;
   assign us         = r_us;
   assign expired    = r_expired;
   assign clean_done = r_clean_done;
   assign tick_1hz   = w_tick;

   always_comb begin
      w_preset = 6'd0;
      case (states)
         2'b01: w_preset = B_CLEAN;
         2'b10: begin
            case (irr_type)
               2'b01:   w_preset = B_SPR;
               2'b10:   w_preset = B_DRIP;
               default: w_preset = 6'd0;
            endcase
         end
         2'b11:   w_preset = B_FILL;
         default: w_preset = 6'd0;
      endcase
   end

   // Load has priority over the tick, so a coincident tick is dropped.
   always_comb begin
      w_state_nxt  = r_state;
      w_ds_nxt     = r_ds;
      w_us_nxt     = r_us;
      w_enter_done = 1'b0;
      if (load) begin
         if (states == 2'b00) begin
            w_state_nxt = S_IDLE;
            w_ds_nxt    = 2'd0;
            w_us_nxt    = 4'd0;
         end else begin
            w_ds_nxt = w_preset[5:4];
            w_us_nxt = w_preset[3:0];
            if (w_preset == 6'd0) begin
               w_state_nxt  = S_DONE;
               w_enter_done = 1'b1;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
      end else if (r_state == S_RUN && w_tick) begin
         if (r_ds == 2'd0 && r_us == 4'd0) begin
            w_state_nxt  = S_DONE;
            w_enter_done = 1'b1;
         end else begin
            if (r_us == 4'd0) begin
               w_us_nxt = 4'd9;
               w_ds_nxt = r_ds - 2'd1;
            end else begin
               w_us_nxt = r_us - 4'd1;
            end
            if (r_ds == 2'd0 && r_us == 4'd1) begin
               w_state_nxt  = S_DONE;
               w_enter_done = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_fg or posedge init_pulse) begin
      if (init_pulse) begin
         r_presc <= '0;
      end else if (load) begin
         r_presc <= '0;
      end else if (!w_freeze) begin
         r_presc <= (r_presc == P_MAX) ? '0 : r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk_fg or posedge init_pulse) begin
      if (init_pulse) begin
         r_state      <= S_IDLE;
         r_ds         <= 2'd0;
         r_us         <= 4'd0;
         r_expired    <= 1'b0;
         r_clean_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ds         <= w_ds_nxt;
         r_us         <= w_us_nxt;
         r_expired    <= (w_state_nxt == S_DONE) && (states != 2'b00);
         r_clean_done <= w_enter_done && (states == 2'b01);
      end
   end

endmodule

// File: tb/tb_irrigation_timer.sv
// Self-checking bench for irrigation_timer: preset table vectors plus
// multi-cycle countdown, borrow, collision, reset and hold sequences.
module tb_irrigation_timer;

   logic       clk_fg = 1'b0;
   logic       init_pulse;
   logic [1:0] states;
   logic [1:0] irr_type;
   logic       hold;
   logic       load;
   logic [1:0] ds;
   logic [3:0] us;
   logic       expired;
   logic       clean_done;
   logic       tick_1hz;

   int n_checks = 0;
   int n_errors = 0;
   int n_cd = 0;
   int n_tk = 0;

   typedef struct {
      logic [1:0] st;
      logic [1:0] it;
      logic [1:0] eds;
      logic [3:0] eus;
      logic       eex;
      logic       ecd;
   } vec_t;

   typedef struct {
      int         idx;
      logic [1:0] eds;
      logic [3:0] eus;
      logic       eex;
      logic       ecd;
   } exp_t;

   vec_t vt[8];
   exp_t sb[$];

   irrigation_timer dut (
      .clk_fg     (clk_fg),
      .init_pulse (init_pulse),
      .states     (states),
      .irr_type   (irr_type),
`ifdef TIMER_PAUSE_EN
      .hold       (hold),
`endif
      .load       (load),
      .ds         (ds),
      .us         (us),
      .expired    (expired),
      .clean_done (clean_done),
      .tick_1hz   (tick_1hz)
   );

   always #5 clk_fg = ~clk_fg;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_cnt(input string nm, input logic [1:0] eds,
                          input logic [3:0] eus, input logic eex);
      chk({nm, ".ds"}, {6'd0, ds}, {6'd0, eds});
      chk({nm, ".us"}, {4'd0, us}, {4'd0, eus});
      chk({nm, ".expired"}, {7'd0, expired}, {7'd0, eex});
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk_fg);
         if (clean_done) n_cd++;
         if (tick_1hz) n_tk++;
      end
   endtask

   // Load is sampled on the next rising edge; returns at the following negedge.
   task automatic load_pulse(input logic [1:0] st, input logic [1:0] it);
      @(posedge clk_fg);
      #1;
      states   = st;
      irr_type = it;
      load     = 1'b1;
      @(posedge clk_fg);
      #1;
      load = 1'b0;
      @(negedge clk_fg);
   endtask

   initial begin
      exp_t e;
      init_pulse = 1'b1;
      states     = 2'b00;
      irr_type   = 2'b00;
      hold       = 1'b0;
      load       = 1'b0;

      vt[0] = '{2'b01, 2'b00, 2'd1, 4'd5, 1'b0, 1'b0};
      vt[1] = '{2'b10, 2'b01, 2'd3, 4'd0, 1'b0, 1'b0};
      vt[2] = '{2'b10, 2'b10, 2'd3, 4'd9, 1'b0, 1'b0};
      vt[3] = '{2'b10, 2'b00, 2'd0, 4'd0, 1'b1, 1'b0};
      vt[4] = '{2'b10, 2'b11, 2'd0, 4'd0, 1'b1, 1'b0};
      vt[5] = '{2'b11, 2'b01, 2'd2, 4'd0, 1'b0, 1'b0};
      vt[6] = '{2'b00, 2'b10, 2'd0, 4'd0, 1'b0, 1'b0};
      vt[7] = '{2'b01, 2'b10, 2'd1, 4'd5, 1'b0, 1'b0};

      repeat (3) @(negedge clk_fg);
      chk_cnt("reset", 2'd0, 4'd0, 1'b0);
      chk("reset.clean_done", {7'd0, clean_done}, 8'd0);
      chk("reset.tick", {7'd0, tick_1hz}, 8'd0);
      @(posedge clk_fg);
      #1 init_pulse = 1'b0;

      for (int i = 0; i < 8; i++) begin
         e.idx = i;
         e.eds = vt[i].eds;
         e.eus = vt[i].eus;
         e.eex = vt[i].eex;
         e.ecd = vt[i].ecd;
         sb.push_back(e);
         load_pulse(vt[i].st, vt[i].it);
         e = sb.pop_front();
         chk_cnt($sformatf("vec%0d", e.idx), e.eds, e.eus, e.eex);
         chk($sformatf("vec%0d.clean_done", e.idx), {7'd0, clean_done},
             {7'd0, e.ecd});
      end

      // Asynchronous reset mid-count at 1:2
      cyc(3 * 224);
      chk_cnt("prereset", 2'd1, 4'd2, 1'b0);
      #2 init_pulse = 1'b1;
      #1;
      chk_cnt("async_reset", 2'd0, 4'd0, 1'b0);
      @(posedge clk_fg);
      #1 init_pulse = 1'b0;

      // Full CLEAN phase countdown
      load_pulse(2'b01, 2'b00);
      n_cd = 0;
      n_tk = 0;
      chk_cnt("clean.load", 2'd1, 4'd5, 1'b0);
      cyc(223);
      chk_cnt("clean.pre_tick", 2'd1, 4'd5, 1'b0);
      cyc(1);
      chk_cnt("clean.first_dec", 2'd1, 4'd4, 1'b0);
      cyc(3135);
      chk_cnt("clean.at01", 2'd0, 4'd1, 1'b0);
      chk("clean.cd_early", n_cd[7:0], 8'd0);
      cyc(1);
      chk_cnt("clean.done", 2'd0, 4'd0, 1'b1);
      chk("clean.cd_pulse", {7'd0, clean_done}, 8'd1);
      cyc(448);
      chk_cnt("clean.hold00", 2'd0, 4'd0, 1'b1);
      chk("clean.cd_count", n_cd[7:0], 8'd1);
      chk("clean.ticks", n_tk[7:0], 8'd17);

      // BCD borrow from 3:0 to 2:9
      load_pulse(2'b10, 2'b10);
      chk_cnt("borrow.load", 2'd3, 4'd9, 1'b0);
      cyc(9 * 224);
      chk_cnt("borrow.30", 2'd3, 4'd0, 1'b0);
      cyc(224);
      chk_cnt("borrow.29", 2'd2, 4'd9, 1'b0);

      // Load coincident with a tick at 0:7
      load_pulse(2'b11, 2'b00);
      chk_cnt("coll.load", 2'd2, 4'd0, 1'b0);
      cyc(13 * 224);
      chk_cnt("coll.07", 2'd0, 4'd7, 1'b0);
      cyc(222);
      @(posedge clk_fg);
      #1;
      states = 2'b11;
      load   = 1'b1;
      @(negedge clk_fg);
      chk("coll.tick", {7'd0, tick_1hz}, 8'd1);
      chk_cnt("coll.before", 2'd0, 4'd7, 1'b0);
      @(posedge clk_fg);
      #1 load = 1'b0;
      @(negedge clk_fg);
      chk_cnt("coll.preset", 2'd2, 4'd0, 1'b0);
      cyc(223);
      chk_cnt("coll.no_dec", 2'd2, 4'd0, 1'b0);
      cyc(1);
      chk_cnt("coll.dec", 2'd1, 4'd9, 1'b0);

`ifdef TIMER_PAUSE_EN
      load_pulse(2'b01, 2'b00);
      cyc(5 * 224);
      chk_cnt("hold.10", 2'd1, 4'd0, 1'b0);
      cyc(100);
      hold = 1'b1;
      n_tk = 0;
      cyc(500);
      chk_cnt("hold.frozen", 2'd1, 4'd0, 1'b0);
      chk("hold.no_tick", n_tk[7:0], 8'd0);
      hold = 1'b0;
      cyc(123);
      chk_cnt("hold.resume_pre", 2'd1, 4'd0, 1'b0);
      cyc(1);
      chk_cnt("hold.resume", 2'd0, 4'd9, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
